dnn_output_capture: RTL and testbench
=====================================

DNN_OUTPUT_CAPTURE -- requirements
Module: dnn_output_capture

Interface
REQ-001 The block SHALL have these parameters, one per line (name, default, meaning):
- DATA_W, 10: captured activation width.
- DEPTH, 200: capture buffer entries.
- ADDR_W, 8: address and count width; DEPTH < 2^ADDR_W.
- IDX_W, 7: cycle index width.
- CNT_W, 16: sample counter width.
- SKIP, 12344: samples ignored before capture in mode 0.

REQ-002 The block SHALL have these ports, one per line (name, direction, width, meaning):
- clk, in, 1: single clock; all state on its rising edge.
- reset, in, 1: asynchronous, active-high.
- clear, in, 1: synchronous clear.
- mode, in, 2: 0 SKIP, 1 CHANGE, 2 RING, 3 OFF.
- cycle_clk, in, 1: one-cycle sample strobe from the DNN core.
- cycle_index, in, IDX_W: current DNN cycle index.
- act_data, in, DATA_W: current DNN output activations.
- rd_addr, in, ADDR_W: logical read address.
- rd_data, out, DATA_W: stored activation at rd_addr.
- rd_index, out, IDX_W: stored cycle_index at rd_addr.
- store_count, out, ADDR_W: valid entries held, 0..DEPTH.
- sample_count, out, CNT_W: cycle_clk strobes seen.
- last_data, out, DATA_W: act_data at the most recent cycle_clk.
- full, out, 1: store_count == DEPTH.
- overflow, out, 1: sticky; a qualified event was dropped or overwrote an entry.

Function
REQ-003 Each cycle_clk SHALL increment sample_count, saturating at all-ones, and load last_data <= act_data.
REQ-004 Each entry SHALL be the pair {cycle_index, act_data} sampled in the cycle of the qualifying event.
REQ-005 Qualifying event per mode:
- mode 0: cycle_clk && sample_count >= SKIP, using the pre-increment value.
- mode 1: any cycle with act_data != 0 && act_data != 1, regardless of cycle_clk.
- mode 2: every cycle_clk.
- mode 3: never.
REQ-006 Modes 0 and 1 (linear) SHALL behave as follows:
- Event with store_count < DEPTH: write at address store_count and increment store_count.
- Event with store_count == DEPTH: no write; set overflow.
REQ-007 Mode 2 (ring) SHALL behave as follows:
- Write at wr_ptr; wr_ptr wraps from DEPTH-1 to 0.
- store_count saturates at DEPTH.
- A write while full overwrites the oldest entry and sets overflow.
REQ-008 Reads SHALL have 1-cycle latency: rd_data/rd_index are registered from the rd_addr presented in the previous cycle.
REQ-009 Read address mapping SHALL be:
- Linear modes: physical = rd_addr.
- Ring mode while full: physical = (wr_ptr + rd_addr) mod DEPTH, so logical 0 is the oldest entry.
- Ring mode not full: physical = rd_addr.
REQ-010 rd_addr >= store_count SHALL return rd_data = 0 and rd_index = 0.
REQ-011 At most one entry SHALL be written per clock; a read of the same entry being written in that cycle returns the old contents.
REQ-012 A mode change without clear SHALL take effect next cycle, keep store_count/wr_ptr unchanged, and use the linear address map whenever the new mode is not 2.
REQ-013 clear SHALL zero the following in one cycle and take priority over a simultaneous event or strobe:
- sample_count, store_count, wr_ptr, overflow, last_data.
- The registered rd_data and rd_index.
- Buffer contents need not be cleared; REQ-010 masks them.
REQ-014 full SHALL be combinational from store_count; all other outputs SHALL be registered.

Reset
REQ-015 Asserting reset SHALL immediately force the following to 0 and hold them while asserted:
- Outputs: rd_data, rd_index, store_count, sample_count, last_data, full, overflow.
- Internal state: wr_ptr.
- Buffer memory is not reset.
REQ-016 The first event SHALL be accepted on the first rising edge after reset deasserts, including a reset release mid-run.

Verification (bench parameters DEPTH=4, SKIP=3)
REQ-017 Mode 0: 6 strobes with act_data = 10..15 -> store_count = 3, entries 13,14,15, sample_count = 6, overflow = 0.
REQ-018 Mode 0: 10 strobes with act_data = 20..29 -> store_count = 4, full = 1, overflow = 1, entries 23..26.
REQ-019 Mode 1: act_data sequence 0,1,5,1,7 held one cycle each with cycle_index = 3,4,5,6,7 -> entries {5,5},{7,7}; store_count = 2.
REQ-020 Mode 2: 6 strobes with act_data = 1..6 -> reads of rd_addr 0..3 return 3,4,5,6; overflow = 1.
REQ-021 clear asserted in the same cycle as a qualifying strobe -> all counters 0, no write; a read of rd_addr 0 returns 0.
REQ-022 reset pulsed mid-capture at store_count = 2 -> all outputs 0 within the same cycle; capture restarts at address 0.

Source files
------------

// File: rtl/dnn_output_capture.sv
// dnn_output_capture: records {cycle_index, act_data} pairs from a DNN core
// under skip, change-detect or ring policies, with a registered read port.
module dnn_output_capture #(
  parameter int DATA_W = 10,
  parameter int DEPTH  = 200,
  parameter int ADDR_W = 8,
  parameter int IDX_W  = 7,
  parameter int CNT_W  = 16,
  parameter int SKIP   = 12344
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic [1:0]        mode,
  input  logic              cycle_clk,
  input  logic [IDX_W-1:0]  cycle_index,
  input  logic [DATA_W-1:0] act_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic [IDX_W-1:0]  rd_index,
  output logic [ADDR_W-1:0] store_count,
  output logic [CNT_W-1:0]  sample_count,
  output logic [DATA_W-1:0] last_data,
  output logic              full,
  output logic              overflow
);

  typedef enum logic [1:0] {
    MODE_SKIP   = 2'd0,
    MODE_CHANGE = 2'd1,
    MODE_RING   = 2'd2,
    MODE_OFF    = 2'd3
  } mode_e;

  localparam int EW = IDX_W + DATA_W;
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0]  SKIP_C  = CNT_W'(SKIP);
  localparam logic [DATA_W-1:0] ONE_D   = DATA_W'(1);

  // Capture storage; contents are masked by store_count, so never reset.
  logic [EW-1:0] mem [DEPTH];

  logic [CNT_W-1:0]  sample_count_q, sample_count_d;
  logic [ADDR_W-1:0] store_count_q, store_count_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic              overflow_q, overflow_d;
  logic [DATA_W-1:0] last_data_q, last_data_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic [IDX_W-1:0]  rd_index_q, rd_index_d;

  mode_e             mode_w;
  logic              is_full;
  logic              event_hit;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W:0]   ring_sum;
  logic [ADDR_W-1:0] rd_phys;
  logic              rd_hit;
  logic [EW-1:0]     rd_entry;

  assign mode_w  = mode_e'(mode);
  assign is_full = (store_count_q == DEPTH_A);

  // Qualify the current cycle as a capture event for the active mode.
  always_comb begin
    event_hit = 1'b0;
    unique case (mode_w)
      MODE_SKIP:   event_hit = cycle_clk && (sample_count_q >= SKIP_C);
      MODE_CHANGE: event_hit = (act_data > ONE_D);
      MODE_RING:   event_hit = cycle_clk;
      MODE_OFF:    event_hit = 1'b0;
    endcase
  end

  // Strobe bookkeeping: saturating sample counter and last activation.
  always_comb begin
    sample_count_d = sample_count_q;
    last_data_d    = last_data_q;
    if (clear) begin
      sample_count_d = '0;
      last_data_d    = '0;
    end else if (cycle_clk) begin
      if (sample_count_q != '1) begin
        sample_count_d = sample_count_q + 1'b1;
      end
      last_data_d = act_data;
    end
  end

  // Write policy: linear fill-and-stop, or ring overwrite of the oldest.
  always_comb begin
    store_count_d = store_count_q;
    wr_ptr_d      = wr_ptr_q;
    overflow_d    = overflow_q;
    wr_en         = 1'b0;
    wr_addr       = store_count_q;
    if (clear) begin
      store_count_d = '0;
      wr_ptr_d      = '0;
      overflow_d    = 1'b0;
    end else if (event_hit) begin
      if (mode_w == MODE_RING) begin
        wr_en   = 1'b1;
        wr_addr = wr_ptr_q;
        if (wr_ptr_q == LAST_A) begin
          wr_ptr_d = '0;
        end else begin
          wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (is_full) begin
          overflow_d = 1'b1;
        end else begin
          store_count_d = store_count_q + 1'b1;
        end
      end else if (is_full) begin
        overflow_d = 1'b1;
      end else begin
        wr_en         = 1'b1;
        wr_addr       = store_count_q;
        store_count_d = store_count_q + 1'b1;
      end
    end
  end

  // Logical-to-physical read mapping; a full ring starts at the oldest.
  always_comb begin
    ring_sum = {1'b0, wr_ptr_q} + {1'b0, rd_addr};
    rd_phys  = rd_addr;
    if (mode_w == MODE_RING && is_full) begin
      if (ring_sum >= DEPTH_X) begin
        rd_phys = ADDR_W'(ring_sum - DEPTH_X);
      end else begin
        rd_phys = ring_sum[ADDR_W-1:0];
      end
    end
    rd_hit   = (rd_addr < store_count_q);
    rd_entry = '0;
    if (rd_hit) begin
      rd_entry = mem[rd_phys[PW-1:0]];
    end
  end

  // Read data for the next cycle; empty slots read back as zero.
  always_comb begin
    rd_data_d  = '0;
    rd_index_d = '0;
    if (!clear) begin
      rd_data_d  = rd_entry[DATA_W-1:0];
      rd_index_d = rd_entry[EW-1:DATA_W];
    end
  end

  // Buffer write port; reads above see the pre-write contents.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr[PW-1:0]] <= {cycle_index, act_data};
    end
  end

  // Control and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sample_count_q <= '0;
      store_count_q  <= '0;
      wr_ptr_q       <= '0;
      overflow_q     <= 1'b0;
      last_data_q    <= '0;
      rd_data_q      <= '0;
      rd_index_q     <= '0;
    end else begin
      sample_count_q <= sample_count_d;
      store_count_q  <= store_count_d;
      wr_ptr_q       <= wr_ptr_d;
      overflow_q     <= overflow_d;
      last_data_q    <= last_data_d;
      rd_data_q      <= rd_data_d;
      rd_index_q     <= rd_index_d;
    end
  end

  assign rd_data      = rd_data_q;
  assign rd_index     = rd_index_q;
  assign store_count  = store_count_q;
  assign sample_count = sample_count_q;
  assign last_data    = last_data_q;
  assign full         = is_full;
  assign overflow     = overflow_q;

endmodule

// File: tb/tb_dnn_output_capture.sv
// tb_dnn_output_capture: directed scenarios plus randomized traffic
// checked against a queue-based reference of the capture buffer.
module tb_dnn_output_capture;

  localparam int DW    = 10;
  localparam int DEPTH = 4;
  localparam int AW    = 3;
  localparam int IW    = 7;
  localparam int CW    = 16;
  localparam int SKIP  = 3;

  logic          clk;
  logic          reset;
  logic          clear;
  logic [1:0]    mode;
  logic          cycle_clk;
  logic [IW-1:0] cycle_index;
  logic [DW-1:0] act_data;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic [IW-1:0] rd_index;
  logic [AW-1:0] store_count;
  logic [CW-1:0] sample_count;
  logic [DW-1:0] last_data;
  logic          full;
  logic          overflow;

  dnn_output_capture #(
    .DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW),
    .IDX_W(IW), .CNT_W(CW), .SKIP(SKIP)
  ) dut (
    .clk(clk), .reset(reset), .clear(clear), .mode(mode),
    .cycle_clk(cycle_clk), .cycle_index(cycle_index),
    .act_data(act_data), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_index(rd_index), .store_count(store_count),
    .sample_count(sample_count), .last_data(last_data),
    .full(full), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int i;
    int d;
  } ent_t;

  // Reference: logical buffer as a queue, oldest entry first.
  ent_t m_q[$];
  int   m_samp;
  int   m_last;
  bit   m_ovf;
  int   m_rd;
  int   m_ri;

  int n_chk;
  int n_fail;

  task automatic model_reset();
    m_q.delete();
    m_samp = 0;
    m_last = 0;
    m_ovf  = 0;
    m_rd   = 0;
    m_ri   = 0;
  endtask

  // Drive one clock of inputs, advance the reference, sample after the edge.
  task automatic step(input bit clr, input int md, input bit cs,
                      input int idx, input int dat, input int ra);
    bit   ev;
    ent_t e;
    clear       = clr;
    mode        = 2'(md);
    cycle_clk   = cs;
    cycle_index = IW'(idx);
    act_data    = DW'(dat);
    rd_addr     = AW'(ra);
    if (clr) begin
      model_reset();
    end else begin
      if (ra < m_q.size()) begin
        m_rd = m_q[ra].d;
        m_ri = m_q[ra].i;
      end else begin
        m_rd = 0;
        m_ri = 0;
      end
      case (md)
        0: ev = cs && (m_samp >= SKIP);
        1: ev = (dat != 0) && (dat != 1);
        2: ev = cs;
        default: ev = 0;
      endcase
      if (ev) begin
        e.i = idx;
        e.d = dat;
        if (md == 2) begin
          m_q.push_back(e);
          if (m_q.size() > DEPTH) begin
            void'(m_q.pop_front());
            m_ovf = 1;
          end
        end else if (m_q.size() < DEPTH) begin
          m_q.push_back(e);
        end else begin
          m_ovf = 1;
        end
      end
      if (cs) begin
        if (m_samp != 65535) m_samp++;
        m_last = dat;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear = 1'b0;
    mode = 2'd3;
    cycle_clk = 1'b0;
    cycle_index = '0;
    act_data = '0;
    rd_addr = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_chk++; if (rd_data !== 0) begin n_fail++;
      $display("FAIL reset_rd_data: got %0d want 0", rd_data); end
    n_chk++; if (rd_index !== 0) begin n_fail++;
      $display("FAIL reset_rd_index: got %0d want 0", rd_index); end
    n_chk++; if (store_count !== 0) begin n_fail++;
      $display("FAIL reset_store: got %0d want 0", store_count); end
    n_chk++; if (sample_count !== 0) begin n_fail++;
      $display("FAIL reset_sample: got %0d want 0", sample_count); end
    n_chk++; if (last_data !== 0) begin n_fail++;
      $display("FAIL reset_last: got %0d want 0", last_data); end
    n_chk++; if (full !== 0) begin n_fail++;
      $display("FAIL reset_full: got %0d want 0", full); end
    n_chk++; if (overflow !== 0) begin n_fail++;
      $display("FAIL reset_ovf: got %0d want 0", overflow); end
    reset = 1'b0;
  endtask

  task automatic test_skip();
    step(1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 6; k++) step(0, 0, 1, k, 10 + k, 0);
    n_chk++; if (store_count !== 3) begin n_fail++;
      $display("FAIL skip_store: got %0d want 3", store_count); end
    n_chk++; if (sample_count !== 6) begin n_fail++;
      $display("FAIL skip_sample: got %0d want 6", sample_count); end
    n_chk++; if (overflow !== 0) begin n_fail++;
      $display("FAIL skip_ovf: got %0d want 0", overflow); end
    n_chk++; if (last_data !== 15) begin n_fail++;
      $display("FAIL skip_last: got %0d want 15", last_data); end
    for (int k = 0; k < 4; k++) begin
      step(0, 0, 0, 0, 0, k);
      n_chk++; if (rd_data !== DW'(k < 3 ? 13 + k : 0)) begin n_fail++;
        $display("FAIL skip_rd%0d: got %0d want %0d", k, rd_data,
                 k < 3 ? 13 + k : 0); end
      n_chk++; if (rd_index !== IW'(k < 3 ? 3 + k : 0)) begin n_fail++;
        $display("FAIL skip_ri%0d: got %0d want %0d", k, rd_index,
                 k < 3 ? 3 + k : 0); end
    end
  endtask

  task automatic test_skip_overflow();
    step(1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 10; k++) step(0, 0, 1, k, 20 + k, 0);
    n_chk++; if (store_count !== 4) begin n_fail++;
      $display("FAIL sovf_store: got %0d want 4", store_count); end
    n_chk++; if (full !== 1) begin n_fail++;
      $display("FAIL sovf_full: got %0d want 1", full); end
    n_chk++; if (overflow !== 1) begin n_fail++;
      $display("FAIL sovf_ovf: got %0d want 1", overflow); end
    for (int k = 0; k < 4; k++) begin
      step(0, 0, 0, 0, 0, k);
      n_chk++; if (rd_data !== DW'(23 + k)) begin n_fail++;
        $display("FAIL sovf_rd%0d: got %0d want %0d", k, rd_data, 23 + k); end
    end
  endtask

  task automatic test_change();
    int seq [5] = '{0, 1, 5, 1, 7};
    step(1, 1, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) step(0, 1, 0, 3 + k, seq[k], 0);
    n_chk++; if (store_count !== 2) begin n_fail++;
      $display("FAIL chg_store: got %0d want 2", store_count); end
    n_chk++; if (sample_count !== 0) begin n_fail++;
      $display("FAIL chg_sample: got %0d want 0", sample_count); end
    for (int k = 0; k < 3; k++) begin
      step(0, 1, 0, 0, 0, k);
      n_chk++; if (rd_data !== DW'(k == 0 ? 5 : k == 1 ? 7 : 0)) begin
        n_fail++;
        $display("FAIL chg_rd%0d: got %0d", k, rd_data); end
      n_chk++; if (rd_index !== IW'(k == 0 ? 5 : k == 1 ? 7 : 0)) begin
        n_fail++;
        $display("FAIL chg_ri%0d: got %0d", k, rd_index); end
    end
  endtask

  task automatic test_ring();
    step(1, 2, 0, 0, 0, 0);
    for (int k = 1; k <= 6; k++) step(0, 2, 1, k, k, 0);
    n_chk++; if (store_count !== 4) begin n_fail++;
      $display("FAIL ring_store: got %0d want 4", store_count); end
    n_chk++; if (overflow !== 1) begin n_fail++;
      $display("FAIL ring_ovf: got %0d want 1", overflow); end
    n_chk++; if (full !== 1) begin n_fail++;
      $display("FAIL ring_full: got %0d want 1", full); end
    for (int k = 0; k < 4; k++) begin
      step(0, 2, 0, 0, 0, k);
      n_chk++; if (rd_data !== DW'(3 + k)) begin n_fail++;
        $display("FAIL ring_rd%0d: got %0d want %0d", k, rd_data, 3 + k); end
      n_chk++; if (rd_index !== IW'(3 + k)) begin n_fail++;
        $display("FAIL ring_ri%0d: got %0d want %0d", k, rd_index, 3 + k); end
    end
  endtask

  task automatic test_clear_priority();
    step(1, 2, 1, 9, 99, 0);
    n_chk++; if (store_count !== 0) begin n_fail++;
      $display("FAIL clr_store: got %0d want 0", store_count); end
    n_chk++; if (sample_count !== 0) begin n_fail++;
      $display("FAIL clr_sample: got %0d want 0", sample_count); end
    n_chk++; if (overflow !== 0) begin n_fail++;
      $display("FAIL clr_ovf: got %0d want 0", overflow); end
    n_chk++; if (last_data !== 0) begin n_fail++;
      $display("FAIL clr_last: got %0d want 0", last_data); end
    n_chk++; if (full !== 0) begin n_fail++;
      $display("FAIL clr_full: got %0d want 0", full); end
    step(0, 2, 0, 0, 0, 0);
    n_chk++; if (rd_data !== 0 || rd_index !== 0) begin n_fail++;
      $display("FAIL clr_read: got %0d/%0d want 0/0", rd_data, rd_index); end
  endtask

  task automatic test_reset_mid();
    step(1, 2, 0, 0, 0, 0);
    step(0, 2, 1, 1, 40, 0);
    step(0, 2, 1, 2, 41, 0);
    n_chk++; if (store_count !== 2) begin n_fail++;
      $display("FAIL rmid_pre: got %0d want 2", store_count); end
    cycle_clk = 1'b0;
    #2 reset = 1'b1;
    #1;
    n_chk++; if ({rd_data, rd_index, store_count, sample_count,
                  last_data, full, overflow} !== '0) begin n_fail++;
      $display("FAIL rmid_zero: store %0d sample %0d last %0d full %0d",
               store_count, sample_count, last_data, full); end
    @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
    step(0, 2, 1, 9, 50, 0);
    n_chk++; if (store_count !== 1) begin n_fail++;
      $display("FAIL rmid_store: got %0d want 1", store_count); end
    step(0, 2, 0, 0, 0, 0);
    n_chk++; if (rd_data !== 50 || rd_index !== 9) begin n_fail++;
      $display("FAIL rmid_read: got %0d/%0d want 50/9", rd_data, rd_index); end
  endtask

  task automatic test_random();
    int md;
    for (int s = 0; s < 12; s++) begin
      md = $urandom_range(0, 3);
      step(1, md, 0, 0, 0, 0);
      for (int c = 0; c < 40; c++) begin
        step(($urandom_range(0, 29) == 0), md, $urandom_range(0, 1),
             $urandom_range(0, 127),
             ($urandom_range(0, 1) == 1) ? $urandom_range(0, 2)
                                         : $urandom_range(0, 1023),
             $urandom_range(0, 5));
        n_chk++; if (rd_data !== DW'(m_rd) || rd_index !== IW'(m_ri)) begin
          n_fail++;
          $display("FAIL rnd_read: got %0d/%0d want %0d/%0d",
                   rd_data, rd_index, m_rd, m_ri); end
        n_chk++; if (store_count !== AW'(m_q.size())) begin n_fail++;
          $display("FAIL rnd_store: got %0d want %0d",
                   store_count, m_q.size()); end
        n_chk++; if (sample_count !== CW'(m_samp)) begin n_fail++;
          $display("FAIL rnd_sample: got %0d want %0d",
                   sample_count, m_samp); end
        n_chk++; if (last_data !== DW'(m_last)) begin n_fail++;
          $display("FAIL rnd_last: got %0d want %0d", last_data, m_last); end
        n_chk++; if (full !== (m_q.size() == DEPTH)) begin n_fail++;
          $display("FAIL rnd_full: got %0d want %0d",
                   full, m_q.size() == DEPTH); end
        n_chk++; if (overflow !== m_ovf) begin n_fail++;
          $display("FAIL rnd_ovf: got %0d want %0d", overflow, m_ovf); end
      end
    end
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    test_reset();
    test_skip();
    test_skip_overflow();
    test_change();
    test_ring();
    test_clear_priority();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
